// File: rtl/vga_sync_decoder_if.sv
// rtl/vga_sync_decoder_if.sv - sync inputs and recovered timing outputs of the VGA sync decoder
interface vga_sync_decoder_if;
  logic        hsync;
  logic        vsync;
  logic [10:0] h_pos;
  logic [9:0]  v_pos;
  logic [9:0]  pixel_x;
  logic [8:0]  pixel_y;
  logic        video_on;
  logic        locked;
  logic        line_err;
  logic        frame_err;

  // master is the timing source; slave is the decoder
  modport master (
    output hsync, vsync,
    input  h_pos, v_pos, pixel_x, pixel_y, video_on, locked, line_err, frame_err
  );

  modport slave (
    input  hsync, vsync,
    output h_pos, v_pos, pixel_x, pixel_y, video_on, locked, line_err, frame_err
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - VGA receive timing decoder
// Recovers h/v position, active-video window and lock status from active-low hsync/vsync.
module vga_sync_decoder #(
  parameter int H_TOTAL    = 800,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int H_ACT      = 640,
  parameter int V_TOTAL    = 525,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int V_ACT      = 480,
  parameter int LOCK_LINES = 4
) (
  input  logic              Clk,
  input  logic              reset,
  vga_sync_decoder_if.slave vid
);
  localparam int GW = $clog2(LOCK_LINES + 1);
  localparam logic [10:0]   H_LAST    = 11'(H_TOTAL - 1);
  localparam logic [10:0]   H_START   = 11'(H_SYNC + H_BP);
  localparam logic [10:0]   H_END     = 11'(H_SYNC + H_BP + H_ACT - 1);
  localparam logic [9:0]    V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]    V_START   = 10'(V_SYNC + V_BP);
  localparam logic [9:0]    V_END     = 10'(V_SYNC + V_BP + V_ACT - 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_LINES - 1);

  typedef enum logic [1:0] {SEARCH, HCOUNT, VWAIT, LOCKED} state_t;

  state_t        state, state_nxt;
  logic          hs_q, vs_q, hs_prev, vs_prev;
  logic [10:0]   h_cnt, h_nxt;
  logic [9:0]    v_cnt, v_nxt;
  logic [GW-1:0] good_cnt, good_nxt;
  logic          bad_pend, bad_nxt;
  logic          hfall, vfall, hwrap, hline;
  logic          good_line, bad_line, frame_bad;
  logic          line_err_nxt, frame_err_nxt;
  logic          lock_nxt, video_nxt;
  logic [9:0]    px_nxt;
  logic [8:0]    py_nxt;
  logic          lock_q, video_q, line_err_q, frame_err_q;
  logic [9:0]    px_q;
  logic [8:0]    py_q;

  // Sync inputs idle high, so the flops reset to 1 to avoid a false edge after reset.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      hs_prev <= 1'b1;
      vs_prev <= 1'b1;
    end else begin
      hs_q    <= vid.hsync;
      vs_q    <= vid.vsync;
      hs_prev <= hs_q;
      vs_prev <= vs_q;
    end
  end

  assign hfall     = hs_prev & ~hs_q;
  assign vfall     = vs_prev & ~vs_q;
  assign hwrap     = (h_cnt == H_LAST) & ~hfall;
  assign hline     = hfall | hwrap;
  assign good_line = hfall & (h_cnt == H_LAST);
  assign bad_line  = (hfall & (h_cnt != H_LAST)) | hwrap;
  assign frame_bad = (vfall & (v_cnt != V_LAST)) | (hline & ~vfall & (v_cnt == V_LAST));

  always_comb begin
    h_nxt = h_cnt + 11'd1;
    if (hfall || h_cnt == H_LAST)
      h_nxt = '0;
  end

  always_comb begin
    v_nxt = v_cnt;
    if (vfall)
      v_nxt = '0;
    else if (hline)
      v_nxt = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
  end

  always_comb begin
    state_nxt     = state;
    good_nxt      = good_cnt;
    bad_nxt       = bad_pend;
    line_err_nxt  = 1'b0;
    frame_err_nxt = 1'b0;
    unique case (state)
      SEARCH: begin
        bad_nxt = 1'b0;
        if (hfall) begin
          state_nxt = HCOUNT;
          good_nxt  = '0;
        end
      end
      HCOUNT: begin
        if (bad_line) begin
          good_nxt = '0;
        end else if (good_line) begin
          good_nxt = good_cnt + GW'(1);
          if (good_cnt == GOOD_LAST)
            state_nxt = VWAIT;
        end
      end
      VWAIT: begin
        if (bad_line) begin
          state_nxt = SEARCH;
        end else if (vfall) begin
          state_nxt = LOCKED;
          bad_nxt   = 1'b0;
        end
      end
      LOCKED: begin
        // One bad line is tolerated; a second before any good line drops lock.
        if (bad_line) begin
          line_err_nxt = 1'b1;
          bad_nxt      = 1'b1;
          if (bad_pend)
            state_nxt = SEARCH;
        end else if (good_line) begin
          bad_nxt = 1'b0;
        end
        if (frame_bad) begin
          frame_err_nxt = 1'b1;
          state_nxt     = SEARCH;
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

  // Outputs are derived from next-state counters so they line up with h_pos/v_pos.
  always_comb begin
    lock_nxt  = (state_nxt == LOCKED);
    video_nxt = lock_nxt &
                (h_nxt >= H_START) & (h_nxt <= H_END) &
                (v_nxt >= V_START) & (v_nxt <= V_END);
    px_nxt    = video_nxt ? 10'(h_nxt - H_START) : 10'd0;
    py_nxt    = video_nxt ? 9'(v_nxt - V_START) : 9'd0;
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state       <= SEARCH;
      good_cnt    <= '0;
      bad_pend    <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      px_q        <= '0;
      py_q        <= '0;
      video_q     <= 1'b0;
      lock_q      <= 1'b0;
      line_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      good_cnt    <= good_nxt;
      bad_pend    <= bad_nxt;
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      px_q        <= px_nxt;
      py_q        <= py_nxt;
      video_q     <= video_nxt;
      lock_q      <= lock_nxt;
      line_err_q  <= line_err_nxt;
      frame_err_q <= frame_err_nxt;
    end
  end

  assign vid.h_pos     = h_cnt;
  assign vid.v_pos     = v_cnt;
  assign vid.pixel_x   = px_q;
  assign vid.pixel_y   = py_q;
  assign vid.video_on  = video_q;
  assign vid.locked    = lock_q;
  assign vid.line_err  = line_err_q;
  assign vid.frame_err = frame_err_q;
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - self-checking bench for vga_sync_decoder
// Uses scaled-down timing (40x30 totals) so every scenario fits in a short run.
module tb_vga_sync_decoder;
  localparam int HT = 40, HS = 4, HBP = 4, HA = 24;
  localparam int VT = 30, VS = 2, VBP = 3, VA = 20, LL = 4;
  localparam int HST = HS + HBP, VST = VS + VBP;
  localparam int MS = 0, MC = 1, MW = 2, ML = 3;

  logic Clk   = 1'b0;
  logic reset = 1'b1;

  vga_sync_decoder_if vif();

  vga_sync_decoder #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_BP(HBP), .H_ACT(HA),
    .V_TOTAL(VT), .V_SYNC(VS), .V_BP(VBP), .V_ACT(VA), .LOCK_LINES(LL)
  ) dut (
    .Clk(Clk),
    .reset(reset),
    .vid(vif)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0, n_bad = 0;
  int cnt_le = 0, cnt_fe = 0;
  int frame_idx = -1;
  bit seen_lock = 0, seen_vid = 0, seen_end = 0;

  int m_hs, m_vs, m_hsp, m_vsp, m_h, m_v, m_mode, m_good, m_badp;
  int e_px, e_py;
  bit e_le, e_fe, e_lock, e_vid;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_hs = 1; m_vs = 1; m_hsp = 1; m_vsp = 1;
    m_h = 0; m_v = 0; m_mode = MS; m_good = 0; m_badp = 0;
    e_px = 0; e_py = 0; e_le = 0; e_fe = 0; e_lock = 0; e_vid = 0;
  endtask

  // One pixel clock of the decoder's behaviour, from the timing rules.
  task automatic model_step();
    bit hf, vf, wrap, bnd, good, bad, ferr;
    hf   = (m_hsp == 1) && (m_hs == 0);
    vf   = (m_vsp == 1) && (m_vs == 0);
    wrap = (m_h == HT - 1) && !hf;
    bnd  = hf || wrap;
    good = hf && (m_h == HT - 1);
    bad  = bnd && !good;
    ferr = vf ? (m_v != VT - 1) : (bnd && m_v == VT - 1);
    e_le = 0;
    e_fe = 0;
    case (m_mode)
      MS: if (hf) begin m_mode = MC; m_good = 0; end
      MC: begin
        if (bad) m_good = 0;
        else if (good) begin
          m_good++;
          if (m_good == LL) m_mode = MW;
        end
      end
      MW: begin
        if (bad) m_mode = MS;
        else if (vf) begin m_mode = ML; m_badp = 0; end
      end
      default: begin
        if (bad) begin
          e_le = 1;
          if (m_badp != 0) m_mode = MS;
          m_badp = 1;
        end else if (good) m_badp = 0;
        if (ferr) begin e_fe = 1; m_mode = MS; end
      end
    endcase
    m_h = (hf || m_h == HT - 1) ? 0 : m_h + 1;
    m_v = vf ? 0 : (bnd ? (m_v + 1) % VT : m_v);
    m_hsp = m_hs; m_hs = int'(vif.hsync);
    m_vsp = m_vs; m_vs = int'(vif.vsync);
    e_lock = (m_mode == ML);
    e_vid  = e_lock && m_h >= HST && m_h < HST + HA && m_v >= VST && m_v < VST + VA;
    e_px   = e_vid ? m_h - HST : 0;
    e_py   = e_vid ? m_v - VST : 0;
  endtask

  initial begin
    logic [43:0] act, exp;
    forever begin
      @(negedge Clk);
      if (reset) begin
        model_reset();
      end else begin
        model_step();
        act = {vif.h_pos, vif.v_pos, vif.pixel_x, vif.pixel_y,
               vif.video_on, vif.locked, vif.line_err, vif.frame_err};
        exp = {11'(m_h), 10'(m_v), 10'(e_px), 9'(e_py), e_vid, e_lock, e_le, e_fe};
        n_cmp++;
        if (act !== exp) begin
          n_bad++;
          $display("FAIL cycle at %0t: got h=%0d v=%0d x=%0d y=%0d von=%0b lk=%0b le=%0b fe=%0b, expected h=%0d v=%0d x=%0d y=%0d von=%0b lk=%0b le=%0b fe=%0b",
                   $time, vif.h_pos, vif.v_pos, vif.pixel_x, vif.pixel_y, vif.video_on,
                   vif.locked, vif.line_err, vif.frame_err,
                   m_h, m_v, e_px, e_py, e_vid, e_lock, e_le, e_fe);
        end
        if (vif.line_err) cnt_le++;
        if (vif.frame_err) begin
          cnt_fe++;
          check("frame_err_drops_lock", vif.locked, 0);
        end
        if (vif.locked && !seen_lock) begin
          seen_lock = 1;
          check("first_lock_h", vif.h_pos, 0);
          check("first_lock_v", vif.v_pos, 0);
          check("first_lock_frame", frame_idx, 1);
        end
        if (vif.video_on && !seen_vid) begin
          seen_vid = 1;
          check("first_video_h", vif.h_pos, 8);
          check("first_video_v", vif.v_pos, 5);
          check("first_video_x", vif.pixel_x, 0);
          check("first_video_y", vif.pixel_y, 0);
        end
        if (vif.locked && vif.h_pos == 11'(HST + HA - 1) && vif.v_pos == 10'(VST) && !seen_end) begin
          seen_end = 1;
          check("last_pixel_video", vif.video_on, 1);
          check("last_pixel_x", vif.pixel_x, 23);
        end
      end
    end
  end

  task automatic drive_line(input int len, input bit hs_en, input bit vs_lo, input int rst_at);
    for (int i = 0; i < len; i++) begin
      @(negedge Clk);
      #2;
      vif.hsync = (hs_en && i < HS) ? 1'b0 : 1'b1;
      vif.vsync = ~vs_lo;
      if (i == rst_at) begin
        check("pre_reset_video_on", vif.video_on, 1);
        reset = 1'b1;
        #1;
        check("async_reset_outputs",
              {vif.h_pos, vif.v_pos, vif.pixel_x, vif.pixel_y,
               vif.video_on, vif.locked, vif.line_err, vif.frame_err}, 0);
      end else if (rst_at >= 0 && i == rst_at + 1) begin
        reset = 1'b0;
      end
    end
  endtask

  task automatic drive_frame(input int lines, input int short_line, input int nohs,
                             input int rst_line, input int rst_pix);
    frame_idx++;
    for (int l = 0; l < lines; l++)
      drive_line((l == short_line) ? HT - 1 : HT,
                 !(l == nohs || l == nohs + 1),
                 l < VS,
                 (l == rst_line) ? rst_pix : -1);
  endtask

  task automatic clean_frame();
    drive_frame(VT, -1, -10, -1, 0);
  endtask

  initial begin
    int le0, fe0;
    vif.hsync = 1'b1;
    vif.vsync = 1'b1;
    repeat (3) @(negedge Clk);
    #2;
    check("reset_outputs",
          {vif.h_pos, vif.v_pos, vif.pixel_x, vif.pixel_y,
           vif.video_on, vif.locked, vif.line_err, vif.frame_err}, 0);
    reset = 1'b0;

    repeat (4) clean_frame();
    check("clean_locked", vif.locked, 1);
    check("clean_no_line_err", cnt_le, 0);
    check("clean_no_frame_err", cnt_fe, 0);
    check("saw_lock", seen_lock, 1);
    check("saw_video", seen_vid, 1);
    check("saw_last_pixel", seen_end, 1);

    le0 = cnt_le; fe0 = cnt_fe;
    drive_frame(VT, 10, -10, -1, 0);
    check("short_line_err_count", cnt_le - le0, 1);
    check("short_line_still_locked", vif.locked, 1);
    clean_frame();
    check("short_line_no_frame_err", cnt_fe - fe0, 0);

    le0 = cnt_le;
    drive_frame(VT, -1, 10, -1, 0);
    check("nohs_err_count", cnt_le - le0, 2);
    check("nohs_unlocked", vif.locked, 0);
    check("nohs_video_off", vif.video_on, 0);
    repeat (2) clean_frame();
    check("nohs_relocked", vif.locked, 1);

    le0 = cnt_le; fe0 = cnt_fe;
    drive_frame(VT - 1, -1, -10, -1, 0);
    clean_frame();
    check("short_frame_err_count", cnt_fe - fe0, 1);
    check("short_frame_no_line_err", cnt_le - le0, 0);
    check("short_frame_relocking", vif.locked, 0);
    clean_frame();
    check("short_frame_relocked", vif.locked, 1);

    drive_frame(VT, -1, -10, 12, 22);
    check("reset_relocking", vif.locked, 0);
    clean_frame();
    check("reset_relocked", vif.locked, 1);
    clean_frame();
    check("final_locked", vif.locked, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side VGA timing decoder: takes active-low hsync/vsync (640x480@60, 800x525 totals) from the sync generator or an external source and recovers pixel coordinates, an active-video flag and lock status. It is the checker/consumer end of the horizontal/vertical counter chain. Pixel-domain logic downstream uses it, and verification benches use it to validate generated timing.

## Interface
- H_TOTAL, 800, clocks per line
- H_SYNC, 96, hsync low width in clocks (informational; not checked)
- H_BP, 48, back porch; active video starts at h_pos = H_SYNC+H_BP
- H_ACT, 640, active pixels per line
- V_TOTAL, 525, lines per frame
- V_SYNC, 2, vsync low width in lines (informational)
- V_BP, 33, back porch lines; active starts at v_pos = V_SYNC+V_BP
- V_ACT, 480, active lines
- LOCK_LINES, 4, consecutive good lines required for horizontal lock
- Clk  input  1  pixel clock; all logic on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- hsync  input  1  active-low horizontal sync, synchronous to Clk
- vsync  input  1  active-low vertical sync, synchronous to Clk
- h_pos  output  11  clocks since last horizontal alignment, 0..H_TOTAL-1
- v_pos  output  10  lines since last vsync fall, 0..V_TOTAL-1
- pixel_x  output  10  h_pos-(H_SYNC+H_BP) when video_on, else 0
- pixel_y  output  9  v_pos-(V_SYNC+V_BP) when video_on, else 0
- video_on  output  1  high when locked and inside active window
- locked  output  1  high in state LOCKED
- line_err  output  1  one-cycle pulse on horizontal period error
- frame_err  output  1  one-cycle pulse on vertical period error

## Operation
- hsync, vsync registered once (hs_q, vs_q) plus one previous-value flop each; hfall = prev_hs & ~hs_q, vfall = prev_vs & ~vs_q.
- h_pos: on hfall load 0; else if h_pos == H_TOTAL-1 wrap to 0; else +1.
- hwrap = (h_pos == H_TOTAL-1) & ~hfall. hline = hfall | hwrap.
- v_pos: on vfall load 0; else on hline, wrap at V_TOTAL-1 to 0, else +1. vfall takes priority over hline in the same cycle.
- good line: hfall with h_pos == H_TOTAL-1. bad line: hfall with h_pos != H_TOTAL-1, or hwrap.
- FSM states: SEARCH, HCOUNT, VWAIT, LOCKED.
  - SEARCH: on hfall -> HCOUNT, good counter = 0.
  - HCOUNT: good line -> counter+1; counter reaching LOCK_LINES -> VWAIT; bad line -> counter = 0, stay.
  - VWAIT: bad line -> SEARCH; vfall -> LOCKED.
  - LOCKED: bad line -> line_err pulse; two consecutive bad lines (no good line between) -> SEARCH. vfall with v_pos != V_TOTAL-1, or v_pos wrapping V_TOTAL-1 -> 0 without vfall -> frame_err pulse and SEARCH.
- line_err and frame_err pulse only in LOCKED. Both can pulse in the same cycle.
- video_on = locked & h_pos in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACT-1] & v_pos in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACT-1]. Defaults: h 144..783, v 35..514.
- All outputs are registered. pixel_x/pixel_y are computed from next-state h_pos/v_pos so they align with video_on.

## Timing
- Reset values: h_pos=0, v_pos=0, pixel_x=0, pixel_y=0, video_on=0, locked=0, line_err=0, frame_err=0, FSM=SEARCH, sync flops=1 (idle high).
- Latency: an input hsync falling at edge N gives hfall in cycle N+2. h_pos reads 0 after edge N+2.
- locked rises on the edge that registers vfall (vsync fall + 2 clocks), provided the line count has been met.
- Reset mid-frame: everything returns to reset values asynchronously. Lock re-acquires with no residue.
- Counter widths fixed at 11/10 bits. Arithmetic unsigned; no overflow possible within the parameter ranges.

## Test plan
- Clean 800x525 timing from the generator, hsync low at h=656..751, vsync low at lines 490..491. Required: locked=1 after 4 good lines + first vfall; video_on first high with pixel_x=0, pixel_y=0 at h_pos=144, v_pos=35; pixel_x=639 at h_pos=783; no err pulses over 3 frames.
- Single line shortened to 799 clocks while locked. Required: one line_err pulse, locked stays 1, h_pos realigns to 0 at that hfall.
- hsync removed for 2 lines while locked. Required: line_err at h_pos wrap twice, then FSM=SEARCH, locked=0, video_on=0.
- Frame with 524 lines. Required: frame_err pulse at vfall (v_pos=523), locked drops the same cycle, and relocks after 4 lines + next vfall.
- Assert reset for 1 clock mid-active-video (h_pos=400, v_pos=200). Required: all outputs 0 immediately, not waiting for a clock edge; locked returns after the relock sequence.
- hfall and vfall in the same cycle. Required: v_pos=0, h_pos=0, no double increment of v_pos.
